logic_event_tracker: RTL and testbench

Parametrised registered logic evaluator with rising-edge event counting. A WIDTH-bit input bus is reduced to one bit by a run-time selectable function, and the result is registered on the falling clock edge. Each 0->1 transition of the registered bit is flagged and counted in a saturating counter. The block serves as the generalised, mode-selectable replacement for the fixed 4-input AND/OR-into-flop stage at the front of the system datapath.

---
 rtl/logic_event_tracker.sv | 74 +++++++
 tb/tb_logic_event_tracker.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/logic_event_tracker.sv
// Mode-selectable reduction of an input bus, registered on the falling edge,
// with 0->1 event detection and a saturating event counter.
module logic_event_tracker #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 8
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic             En,
    input  logic             Clr,
    input  logic [1:0]       Mode,
    input  logic [WIDTH-1:0] In,
    output logic             Q,
    output logic             Rise,
    output logic [CNT_W-1:0] Count,
    output logic             Sat
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic             upper_or;
    logic             z;
    logic             rise_next;
    logic [CNT_W-1:0] cnt_next;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (c == CNT_MAX) ? c : c + 1'b1;
    endfunction

    // Bits above the AND pair; empty (zero) when WIDTH is 2.
    always_comb begin
        upper_or = 1'b0;
        for (int i = 2; i < WIDTH; i++) begin
            upper_or = upper_or | In[i];
        end
    end

    always_comb begin
        case (Mode)
            2'b00:   z = (In[0] & In[1]) | upper_or;
            2'b01:   z = &In;
            2'b10:   z = |In;
            default: z = ^In;
        endcase
    end

    // Clear wins over a coincident rise; the pulse itself still appears.
    always_comb begin
        rise_next = z & ~Q;
        if (Clr)
            cnt_next = '0;
        else if (rise_next)
            cnt_next = sat_inc(Count);
        else
            cnt_next = Count;
    end

    always_ff @(negedge Clk) begin
        if (Rst) begin
            Q     <= 1'b0;
            Rise  <= 1'b0;
            Count <= '0;
            Sat   <= 1'b0;
        end else if (En) begin
            Q     <= z;
            Rise  <= rise_next;
            Count <= cnt_next;
            Sat   <= (cnt_next == CNT_MAX);
        end else begin
            Rise  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_logic_event_tracker.sv
// Scoreboard bench for logic_event_tracker (WIDTH=4, CNT_W=3): a reference
// model pushes expected outputs at drive time, compared after each falling edge.
module tb_logic_event_tracker;

    localparam int WIDTH = 4;
    localparam int CNT_W = 3;

    logic             Clk = 1'b0;
    logic             Rst = 1'b1;
    logic             En = 1'b0;
    logic             Clr = 1'b0;
    logic [1:0]       Mode = 2'b00;
    logic [WIDTH-1:0] In = '0;
    logic             Q;
    logic             Rise;
    logic [CNT_W-1:0] Count;
    logic             Sat;

    typedef struct {
        logic       q;
        logic       rise;
        int         count;
        logic       sat;
        string      tag;
    } exp_t;

    exp_t exp_q[$];

    int checks = 0;
    int errors = 0;

    logic m_q = 1'b0;
    logic m_rise = 1'b0;
    int   m_cnt = 0;
    logic m_sat = 1'b0;

    logic_event_tracker #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .Clk   (Clk),
        .Rst   (Rst),
        .En    (En),
        .Clr   (Clr),
        .Mode  (Mode),
        .In    (In),
        .Q     (Q),
        .Rise  (Rise),
        .Count (Count),
        .Sat   (Sat)
    );

    always #5 Clk = ~Clk;

    initial begin
        #200000;
        $display("FAIL watchdog timeout checks=%0d", checks);
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic model_z(input logic [1:0] m, input logic [3:0] d);
        case (m)
            2'b00:   return (d[0] & d[1]) | d[2] | d[3];
            2'b01:   return d == 4'b1111;
            2'b10:   return d != 4'b0000;
            default: return d[0] ^ d[1] ^ d[2] ^ d[3];
        endcase
    endfunction

    // Drive one cycle of stimulus, advance the model, then compare after the edge.
    task automatic step(input string tag, input logic rst, input logic en,
                        input logic clr, input logic [1:0] m, input logic [3:0] d);
        exp_t e;
        logic zz;
        @(posedge Clk);
        Rst  = rst;
        En   = en;
        Clr  = clr;
        Mode = m;
        In   = d;
        if (rst) begin
            m_q = 0; m_rise = 0; m_cnt = 0; m_sat = 0;
        end else if (en) begin
            zz = model_z(m, d);
            m_rise = zz && !m_q;
            if (clr) m_cnt = 0;
            else if (m_rise && m_cnt < 7) m_cnt = m_cnt + 1;
            m_sat = (m_cnt == 7);
            m_q = zz;
        end else begin
            m_rise = 0;
        end
        e.q = m_q; e.rise = m_rise; e.count = m_cnt; e.sat = m_sat; e.tag = tag;
        exp_q.push_back(e);
        @(negedge Clk);
        #1;
        if (exp_q.size() == 0) begin
            chk({tag, "_queue"}, 0, 1);
        end else begin
            e = exp_q.pop_front();
            chk({e.tag, "_Q"}, int'(Q), int'(e.q));
            chk({e.tag, "_Rise"}, int'(Rise), int'(e.rise));
            chk({e.tag, "_Count"}, int'(Count), e.count);
            chk({e.tag, "_Sat"}, int'(Sat), int'(e.sat));
        end
    endtask

    initial begin
        // Reset hold, then first rise
        step("rst0", 1, 0, 0, 2'b00, 4'b0000);
        step("rst1", 1, 1, 1, 2'b00, 4'b1111);
        step("idle0", 0, 1, 0, 2'b00, 4'b0000);
        step("idle1", 0, 1, 0, 2'b00, 4'b0000);
        step("first_rise", 0, 1, 0, 2'b00, 4'b1100);
        step("held_high", 0, 1, 0, 2'b00, 4'b1100);

        // Mode sweep
        step("mode00", 0, 1, 0, 2'b00, 4'b1011);
        step("mode01", 0, 1, 0, 2'b01, 4'b1011);
        step("mode10", 0, 1, 0, 2'b10, 4'b1011);
        step("mode11", 0, 1, 0, 2'b11, 4'b1011);
        step("pair_lo", 0, 1, 0, 2'b00, 4'b0001);
        step("pair_hi", 0, 1, 0, 2'b00, 4'b0011);
        step("xor_even", 0, 1, 0, 2'b11, 4'b0110);
        step("and_all", 0, 1, 0, 2'b01, 4'b1111);

        // Saturation over 10 rises
        step("clr_a", 0, 1, 1, 2'b10, 4'b0000);
        for (int i = 0; i < 10; i++) begin
            step($sformatf("sat_rise%0d", i + 1), 0, 1, 0, 2'b10, 4'b1111);
            step($sformatf("sat_fall%0d", i + 1), 0, 1, 0, 2'b10, 4'b0000);
        end
        step("sat_clr", 0, 1, 1, 2'b10, 4'b0000);

        // Clear coincident with a rise, Count at 3
        for (int i = 0; i < 3; i++) begin
            step("pre3_hi", 0, 1, 0, 2'b10, 4'b0100);
            step("pre3_lo", 0, 1, 0, 2'b10, 4'b0000);
        end
        step("clr_rise", 0, 1, 1, 2'b10, 4'b1000);
        step("after_clr", 0, 1, 0, 2'b10, 4'b0000);

        // Enable gating, with Clr ignored while disabled
        for (int i = 0; i < 4; i++)
            step("gated", 0, 0, i[0], 2'b10, (i % 2 == 0) ? 4'b1111 : 4'b0000);
        step("gap_rise", 0, 1, 0, 2'b10, 4'b1111);
        step("gap_hold", 0, 0, 0, 2'b10, 4'b0000);

        // Mid-operation reset
        step("pre5_lo", 0, 1, 0, 2'b10, 4'b0000);
        for (int i = 0; i < 4; i++) begin
            step("pre5_hi", 0, 1, 0, 2'b10, 4'b0010);
            step("pre5_lo", 0, 1, 0, 2'b10, 4'b0000);
        end
        step("pre5_last", 0, 1, 0, 2'b10, 4'b0010);
        step("pre5_fall", 0, 1, 0, 2'b10, 4'b0000);
        step("mid_rst", 1, 1, 0, 2'b10, 4'b1111);
        step("post_rst", 0, 1, 0, 2'b10, 4'b1111);

        // Random traffic
        for (int i = 0; i < 60; i++)
            step("rand", ($urandom_range(0, 19) == 0), ($urandom_range(0, 3) != 0),
                 ($urandom_range(0, 9) == 0), 2'($urandom_range(0, 3)),
                 4'($urandom_range(0, 15)));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
